// File: rtl/aes_sbox.sv
// Purpose: AES forward S-box (FIPS-197 SubBytes) for one byte, computed as GF(2^8) inverse plus affine map.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows input.
// Ports: byte_val (8b input byte), sub_val (8b substituted byte).
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Multiplicative inverse as x^254 via an addition chain; 0 maps to 0 naturally.
    always_comb begin
        x2   = gf_mul(byte_val, byte_val);
        x3   = gf_mul(x2, byte_val);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign sub_val = inv
                   ^ {inv[6:0], inv[7]}
                   ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]}
                   ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Purpose: iterative AES-128 key expansion, emits round keys 0..10 from one working register.
// Latency: round 0 one cycle after key accept, then one round key per cycle; 12-cycle key-to-key period.
// Backpressure: round_key_ready low holds all outputs stable indefinitely; key_ready low while expanding.
// Ports: clk, rst (async active-high); key_in/key_valid/key_ready accept a cipher key;
//        round_key/round_idx/last_round/round_key_valid/round_key_ready present round keys.
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         last_round,
    output logic         round_key_valid,
    input  logic         round_key_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   state;
    logic [127:0] work;
    logic [3:0]   idx;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon;

    assign {w0, w1, w2, w3} = work;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (rot[8*g +: 8]),
            .sub_val  (sub[8*g +: 8])
        );
    end

    // Round constant for the key being produced next (round idx+1).
    always_comb begin
        rcon = 8'h00;
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sub ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            work  <= 128'h0;
            idx   <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (key_valid) begin
                work  <= key_in;
                idx   <= 4'd0;
                state <= ST_RUN;
            end
        end else begin
            if (round_key_ready) begin
                if (idx == 4'd10) begin
                    // Index cleared on exit so last_round cannot linger while idle;
                    // the working register keeps the final round key.
                    state <= ST_IDLE;
                    idx   <= 4'd0;
                end else begin
                    work <= {n0, n1, n2, n3};
                    idx  <= idx + 4'd1;
                end
            end
        end
    end

    assign key_ready       = (state == ST_IDLE);
    assign round_key_valid = (state == ST_RUN);
    assign round_key       = work;
    assign round_idx       = idx;
    assign last_round      = (idx == 4'd10);

endmodule
